// File: rtl/multi_decade_updown_counter.sv
// ----------------------------------------------------------------------------
// multi_decade_updown_counter
// Cascaded BCD up/down counter with DIGITS decades, configurable wrap or
// saturate behaviour at the limits, synchronous clear and parallel load.
//
// Parameters
//   DIGITS : number of BCD decades (1..8)
//   WRAP   : 1 = wrap around at the limits, 0 = saturate at the limits
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : asynchronous active-high reset
//   enable     : count-step request for this cycle
//   up         : direction, 1 = increment, 0 = decrement
//   clear      : synchronous clear to zero (highest synchronous priority)
//   load       : synchronous parallel load of load_value
//   load_value : load data, digit 0 in bits [3:0]
//   count      : registered BCD count, digit 0 (ones) in bits [3:0]
//   terminal   : combinational, enabled step against the current limit;
//                suitable as the enable of a cascaded instance
//   rollover   : registered one-cycle pulse on a wrap or saturation event
//   load_err   : registered one-cycle pulse when a load held a non-BCD nibble
// ----------------------------------------------------------------------------
module multi_decade_updown_counter #(
  parameter int unsigned DIGITS = 3,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  terminal,
  output logic                  rollover,
  output logic                  load_err
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] count_nxt;
  logic         rollover_nxt;
  logic         load_err_nxt;
  logic         all_nine;
  logic         all_zero;
  logic         at_limit;

  // Limit detection on the current count.
  always_comb begin
    all_nine = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (count[4*i +: 4] != 4'd9) all_nine = 1'b0;
      if (count[4*i +: 4] != 4'd0) all_zero = 1'b0;
    end
  end

  assign at_limit = up ? all_nine : all_zero;

  // Same condition that raises rollover on the next edge.
  assign terminal = enable & ~clear & ~load & at_limit;

  // Next-state: clear > load > enable > hold.
  always_comb begin
    logic       carry;
    logic [3:0] digit;
    count_nxt    = count;
    rollover_nxt = 1'b0;
    load_err_nxt = 1'b0;
    carry        = 1'b1;
    digit        = 4'd0;
    if (clear) begin
      count_nxt = '0;
    end else if (load) begin
      // Non-BCD nibbles are clamped to 9 so no digit ever exceeds 9.
      for (int i = 0; i < int'(DIGITS); i++) begin
        digit = load_value[4*i +: 4];
        if (digit > 4'd9) begin
          count_nxt[4*i +: 4] = 4'd9;
          load_err_nxt        = 1'b1;
        end else begin
          count_nxt[4*i +: 4] = digit;
        end
      end
    end else if (enable) begin
      rollover_nxt = at_limit;
      if (!(at_limit && (WRAP == 1'b0))) begin
        // Carry/borrow ripples through every decade in one cycle.
        for (int i = 0; i < int'(DIGITS); i++) begin
          digit = count[4*i +: 4];
          if (carry) begin
            if (up) begin
              if (digit >= 4'd9) begin
                count_nxt[4*i +: 4] = 4'd0;
              end else begin
                count_nxt[4*i +: 4] = digit + 4'd1;
                carry               = 1'b0;
              end
            end else begin
              if (digit == 4'd0) begin
                count_nxt[4*i +: 4] = 4'd9;
              end else begin
                count_nxt[4*i +: 4] = digit - 4'd1;
                carry               = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  // State and registered flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      rollover <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= count_nxt;
      rollover <= rollover_nxt;
      load_err <= load_err_nxt;
    end
  end

endmodule

// File: doc/multi_decade_updown_counter.md
MULTI_DECADE_UPDOWN_COUNTER -- requirements
Module: multi_decade_updown_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 3, giving the number of BCD decades (legal range 1..8).
REQ-002 The block SHALL have parameter WRAP, default 1, where 1 means wrap at the limits and 0 means saturate at the limits.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: the asynchronous, active-high reset.
REQ-005 Port enable SHALL be an input, 1 bit: count-step request for the current cycle.
REQ-006 Port up SHALL be an input, 1 bit: direction, 1 means increment and 0 means decrement.
REQ-007 Port clear SHALL be an input, 1 bit: synchronous clear to zero.
REQ-008 Port load SHALL be an input, 1 bit: synchronous parallel load.
REQ-009 Port load_value SHALL be an input, 4*DIGITS bits: load data, with digit 0 in bits [3:0].
REQ-010 Port count SHALL be an output, 4*DIGITS bits: registered BCD value, with digit 0 (ones) in bits [3:0].
REQ-011 Port terminal SHALL be an output, 1 bit: combinational; high when enable=1 and the count is at the limit for the current direction (all 9s when up=1, all 0s when up=0).
REQ-012 Port rollover SHALL be an output, 1 bit: registered one-cycle pulse on a wrap or saturation event.
REQ-013 Port load_err SHALL be an output, 1 bit: registered one-cycle pulse when a load contains a non-BCD digit.

Function
REQ-014 The block SHALL apply control priority per cycle in this order: clear > load > enable > hold.
REQ-015 On clear=1, count SHALL become 0 at the next edge, and rollover and load_err SHALL be 0 in the following cycle.
REQ-016 On load=1 (clear=0), each digit SHALL take its load_value nibble.
REQ-017 During a load, any load_value nibble greater than 9 SHALL be stored as 9, and load_err SHALL pulse high for exactly the next cycle.
REQ-018 On enable=1 with up=1, digit k SHALL increment when all digits below k equal 9; a digit equal to 9 that increments SHALL become 0.
REQ-019 On enable=1 with up=0, digit k SHALL decrement when all digits below k equal 0; a digit equal to 0 that decrements SHALL become 9.
REQ-020 Carry and borrow SHALL ripple through all DIGITS within one cycle, so count changes by exactly 1 per enabled cycle.
REQ-021 At the upper limit (up=1, count all 9s, enable=1) with WRAP=1, count SHALL become all 0s; with WRAP=0, count SHALL hold at all 9s.
REQ-022 At the upper limit event of REQ-021, rollover SHALL be 1 in the next cycle for either WRAP setting.
REQ-023 At the lower limit (up=0, count all 0s, enable=1) with WRAP=1, count SHALL become all 9s; with WRAP=0, count SHALL hold at all 0s.
REQ-024 At the lower limit event of REQ-023, rollover SHALL be 1 in the next cycle for either WRAP setting.
REQ-025 With WRAP=0 and the counter held at a limit, rollover SHALL pulse on every enabled cycle that pushes against that limit.
REQ-026 terminal SHALL equal rollover's next-state condition (limit reached, enable=1, load=0, clear=0) so that it can feed the enable of a cascaded instance.
REQ-027 A change of up between cycles SHALL take effect on the next enabled edge with no dead cycle.
REQ-028 When a load and enable are asserted together, the load SHALL win, and neither a count nor a rollover SHALL occur that cycle.
REQ-029 Once an invalid nibble has been clamped to 9, no digit SHALL ever hold a value greater than 9.

Reset
REQ-030 While reset=1, count, rollover and load_err SHALL be 0 immediately, independent of clk.
REQ-031 Reset SHALL take precedence over all other inputs.
REQ-032 A reset asserted mid-count SHALL abort the count, with no partial carry retained.
REQ-033 After reset is released, the first enabled edge SHALL produce count=1 when up=1, or the limit value when up=0 (all 9s if WRAP=1, 0 held with rollover if WRAP=0).

Verification
REQ-034 The bench SHALL cover: DIGITS=3, WRAP=1, reset then 1000 enabled up cycles -> count returns to 000, rollover pulses once at the 999->000 step, terminal high only while count=999.
REQ-035 The bench SHALL cover: DIGITS=3, WRAP=1, load 100 then one down step -> 099; a further 100 down steps -> 999 with one rollover pulse.
REQ-036 The bench SHALL cover: DIGITS=2, WRAP=0, load 98 then 3 up steps -> 99, 99, 99, with rollover pulses on the 2nd and 3rd steps only.
REQ-037 The bench SHALL cover: load 0xA5F (DIGITS=3) -> count=959, load_err pulses one cycle; load with enable together -> loaded value with no step.
REQ-038 The bench SHALL cover: count at 456, assert reset asynchronously between edges -> count=000 before the next edge; clear and load together -> 000.
REQ-039 The bench SHALL cover: alternating up and down every cycle from 010 -> 011, 010, 011, with no rollover.
